// File: rtl/slc3_mem_ctrl.sv
// SLC-3 memory/IO bus controller: sequences SRAM strobes with configurable wait states
// and decodes one address as a switch-read / hex-display-write IO register.
module slc3_mem_ctrl #(
    parameter int unsigned     ADDR_W      = 20,
    parameter int unsigned     DATA_W      = 16,
    parameter int unsigned     WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR   = 20'hFFFFF
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    input  logic [DATA_W-1:0]   Switches,
    output logic [DATA_W-1:0]   hex_data,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_ce_n,
    output logic                mem_oe_n,
    output logic                mem_we_n,
    output logic [DATA_W/8-1:0] mem_be_n,
    input  logic [DATA_W-1:0]   mem_dq_i,
    output logic [DATA_W-1:0]   mem_dq_o,
    output logic                mem_dq_oe
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_IO     = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic              r_io;
    logic [NB-1:0]     r_be;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_hex;

    logic w_access;
    logic w_done;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_io    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_hex   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_we    <= req_we;
                        r_be    <= req_be;
                        r_wdata <= req_wdata;
                        r_io    <= (req_addr == IO_ADDR);
                        if (req_addr == IO_ADDR) begin
                            r_state <= S_IO;
                        end else begin
                            r_state <= S_ACCESS;
                            r_cnt   <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                S_ACCESS: begin
                    // Read data is sampled on the final cycle of the strobe window
                    if (r_cnt == '0) begin
                        if (!r_we) begin
                            r_rdata <= mem_dq_i;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_IO: begin
                    if (!r_we) begin
                        r_rdata <= Switches;
                    end else begin
                        for (int i = 0; i < NB; i++) begin
                            if (r_be[i]) begin
                                r_hex[8*i +: 8] <= r_wdata[8*i +: 8];
                            end
                        end
                    end
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_access = (r_state == S_ACCESS);
    assign w_done   = (r_state == S_DONE);

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = w_done;
    assign resp_rdata = r_rdata;
    assign hex_data   = r_hex;

    assign mem_addr  = r_addr;
    assign mem_ce_n  = !w_access;
    assign mem_oe_n  = !(w_access && !r_we);
    assign mem_we_n  = !(w_access && r_we && (|r_be));
    assign mem_be_n  = w_access ? (r_we ? ~r_be : '0) : '1;
    assign mem_dq_o  = r_wdata;
    // Write data stays driven through DONE as a hold cycle after WE rises
    assign mem_dq_oe = r_we && !r_io && (w_access || w_done);

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Directed bench for slc3_mem_ctrl: a WAIT_CYCLES=2 instance for the main sequence and a
// WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_slc3_mem_ctrl;

    logic        Clk;
    logic        Reset;

    logic        req_valid, req_ready, req_we, resp_valid;
    logic [1:0]  req_be, mem_be_n;
    logic [19:0] req_addr, mem_addr;
    logic [15:0] req_wdata, resp_rdata, Switches, hex_data, mem_dq_i, mem_dq_o;
    logic        mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe;

    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid;
    logic [1:0]  b_req_be, b_mem_be_n;
    logic [19:0] b_req_addr, b_mem_addr;
    logic [15:0] b_req_wdata, b_resp_rdata, b_Switches, b_hex_data, b_mem_dq_i, b_mem_dq_o;
    logic        b_mem_ce_n, b_mem_oe_n, b_mem_we_n, b_mem_dq_oe;

    int checks = 0;
    int errors = 0;

    slc3_mem_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(2), .IO_ADDR(20'hFFFFF)) u_dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_be     (req_be),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .Switches   (Switches),
        .hex_data   (hex_data),
        .mem_addr   (mem_addr),
        .mem_ce_n   (mem_ce_n),
        .mem_oe_n   (mem_oe_n),
        .mem_we_n   (mem_we_n),
        .mem_be_n   (mem_be_n),
        .mem_dq_i   (mem_dq_i),
        .mem_dq_o   (mem_dq_o),
        .mem_dq_oe  (mem_dq_oe)
    );

    slc3_mem_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(0), .IO_ADDR(20'hFFFFF)) u_dut0 (
        .Clk        (Clk),
        .Reset      (Reset),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_we     (b_req_we),
        .req_be     (b_req_be),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .resp_valid (b_resp_valid),
        .resp_rdata (b_resp_rdata),
        .Switches   (b_Switches),
        .hex_data   (b_hex_data),
        .mem_addr   (b_mem_addr),
        .mem_ce_n   (b_mem_ce_n),
        .mem_oe_n   (b_mem_oe_n),
        .mem_we_n   (b_mem_we_n),
        .mem_be_n   (b_mem_be_n),
        .mem_dq_i   (b_mem_dq_i),
        .mem_dq_o   (b_mem_dq_o),
        .mem_dq_oe  (b_mem_dq_oe)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single accepting edge, then drops req_valid.
    task automatic send(input logic we, input logic [1:0] be, input logic [19:0] addr,
                        input logic [15:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        Reset     = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_be = 2'b00; req_addr = '0; req_wdata = '0;
        Switches  = '0;   mem_dq_i = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_be = 2'b00; b_req_addr = '0;
        b_req_wdata = '0;   b_Switches = '0; b_mem_dq_i = '0;
        #2;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_hex", hex_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
        chk("rst_be_n", mem_be_n, 2'b11);
        chk("rst_dq_o", mem_dq_o, 0);
        chk("rst_dq_oe", mem_dq_oe, 0);
        #10 Reset = 1'b1;
        tick();

        // WAIT_CYCLES=0 instance, req_valid held high across two accesses
        b_req_valid = 1'b1; b_req_addr = 20'h00005; b_mem_dq_i = 16'h1111;
        tick();
        chk("w0_acc1_ce", b_mem_ce_n, 0);
        chk("w0_acc1_ready", b_req_ready, 0);
        chk("w0_acc1_resp", b_resp_valid, 0);
        tick();
        chk("w0_done1_resp", b_resp_valid, 1);
        chk("w0_done1_rdata", b_resp_rdata, 16'h1111);
        chk("w0_done1_ce", b_mem_ce_n, 1);
        chk("w0_done1_ready", b_req_ready, 0);
        b_mem_dq_i = 16'h2222;
        tick();
        chk("w0_idle_ready", b_req_ready, 1);
        chk("w0_idle_resp", b_resp_valid, 0);
        chk("w0_idle_ce", b_mem_ce_n, 1);
        tick();
        chk("w0_acc2_ce", b_mem_ce_n, 0);
        b_req_valid = 1'b0;
        tick();
        chk("w0_done2_resp", b_resp_valid, 1);
        chk("w0_done2_rdata", b_resp_rdata, 16'h2222);
        tick();
        chk("w0_end_resp", b_resp_valid, 0);

        // SRAM read, WAIT_CYCLES=2
        mem_dq_i = 16'hBEEF;
        send(1'b0, 2'b00, 20'h00010, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            chk("rd_ce", mem_ce_n, 0);
            chk("rd_oe", mem_oe_n, 0);
            chk("rd_we", mem_we_n, 1);
            chk("rd_be_n", mem_be_n, 2'b00);
            chk("rd_addr", mem_addr, 20'h00010);
            chk("rd_resp", resp_valid, 0);
            chk("rd_ready", req_ready, 0);
            tick();
        end
        chk("rd_done_resp", resp_valid, 1);
        chk("rd_done_rdata", resp_rdata, 16'hBEEF);
        chk("rd_done_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
        mem_dq_i = 16'h0000;
        tick();
        chk("rd_idle_resp", resp_valid, 0);
        chk("rd_idle_ready", req_ready, 1);
        chk("rd_idle_rdata", resp_rdata, 16'hBEEF);

        // SRAM write, upper lane only
        send(1'b1, 2'b10, 20'h00020, 16'h1234);
        for (int k = 0; k < 3; k++) begin
            chk("wr_ce", mem_ce_n, 0);
            chk("wr_we", mem_we_n, 0);
            chk("wr_oe", mem_oe_n, 1);
            chk("wr_be_n", mem_be_n, 2'b01);
            chk("wr_dq_oe", mem_dq_oe, 1);
            chk("wr_dq_o", mem_dq_o, 16'h1234);
            chk("wr_addr", mem_addr, 20'h00020);
            tick();
        end
        chk("wr_done_resp", resp_valid, 1);
        chk("wr_done_dq_oe", mem_dq_oe, 1);
        chk("wr_done_dq_o", mem_dq_o, 16'h1234);
        chk("wr_done_we", mem_we_n, 1);
        chk("wr_done_rdata", resp_rdata, 16'hBEEF);
        tick();
        chk("wr_idle_dq_oe", mem_dq_oe, 0);
        chk("wr_idle_resp", resp_valid, 0);

        // SRAM write with no lanes enabled
        send(1'b1, 2'b00, 20'h00030, 16'h5555);
        chk("wr0_ce", mem_ce_n, 0);
        chk("wr0_we", mem_we_n, 1);
        tick(); tick();
        chk("wr0_we_last", mem_we_n, 1);
        tick();
        chk("wr0_done_resp", resp_valid, 1);
        tick();

        // IO read: address one bit off IO_ADDR is still SRAM
        mem_dq_i = 16'h7777;
        send(1'b0, 2'b00, 20'hFFFFE, 16'h0000);
        chk("alias_ce", mem_ce_n, 0);
        tick(); tick(); tick(); tick();
        Switches = 16'hA5C3;
        send(1'b0, 2'b00, 20'hFFFFF, 16'h0000);
        chk("io_rd_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
        chk("io_rd_resp0", resp_valid, 0);
        tick();
        chk("io_rd_resp", resp_valid, 1);
        chk("io_rd_rdata", resp_rdata, 16'hA5C3);
        chk("io_rd_dq_oe", mem_dq_oe, 0);
        tick();

        // IO writes with lane masks
        send(1'b1, 2'b11, 20'hFFFFF, 16'hFFFF);
        chk("io_wr1_ce", mem_ce_n, 1);
        tick();
        chk("io_wr1_resp", resp_valid, 1);
        chk("io_wr1_hex", hex_data, 16'hFFFF);
        chk("io_wr1_dq_oe", mem_dq_oe, 0);
        chk("io_wr1_rdata", resp_rdata, 16'hA5C3);
        tick();
        send(1'b1, 2'b01, 20'hFFFFF, 16'h0012);
        tick();
        chk("io_wr2_hex", hex_data, 16'hFF12);
        tick();
        send(1'b1, 2'b00, 20'hFFFFF, 16'h3456);
        tick();
        chk("io_wr3_resp", resp_valid, 1);
        chk("io_wr3_hex", hex_data, 16'hFF12);
        tick();

        // Reset pulse in the middle of a pending read
        send(1'b0, 2'b00, 20'h00040, 16'h0000);
        tick();
        chk("mid_ce_pre", mem_ce_n, 0);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
        chk("mid_rst_be_n", mem_be_n, 2'b11);
        chk("mid_rst_resp", resp_valid, 0);
        chk("mid_rst_hex", hex_data, 0);
        #2 Reset = 1'b1;
        tick();
        chk("mid_post_ready", req_ready, 1);
        chk("mid_post_resp", resp_valid, 0);
        tick();
        chk("mid_post_resp2", resp_valid, 0);
        chk("mid_post_hex", hex_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slc3_mem_ctrl.md
Name: slc3_mem_ctrl

Overview:
Parametrised memory/IO bus controller for the SLC-3 CPU top level. It takes single-access requests from the datapath and control unit over a valid/ready handshake and sequences the SRAM strobes with a configurable number of wait states. One address is decoded as memory-mapped IO: reads return the switch inputs, and writes latch a display register. It generalises the fixed-width Mem2IO path to any data/address width with byte-lane enables and wait-state timing.

Parameters:
ADDR_W, 20, address width
DATA_W, 16, data width; must be a multiple of 8; NB = DATA_W/8 byte lanes
WAIT_CYCLES, 2, extra SRAM access cycles beyond the first (0 is legal)
IO_ADDR, 20'hFFFFF, full-width address decoded as the IO register (ADDR_W bits)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous reset, active-low
req_valid  in  1  access request
req_ready  out  1  controller idle, can accept a request
req_we  in  1  1=write, 0=read
req_be  in  NB  byte-lane enables for writes
req_addr  in  ADDR_W  access address
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle completion pulse (reads and writes)
resp_rdata  out  DATA_W  read data, valid when resp_valid=1
Switches  in  DATA_W  IO read source
hex_data  out  DATA_W  IO display register
mem_addr  out  ADDR_W  registered SRAM address
mem_ce_n, mem_oe_n, mem_we_n  out  1 each  SRAM strobes, active-low
mem_be_n  out  NB  SRAM byte enables, active-low
mem_dq_i  in  DATA_W  SRAM read data
mem_dq_o  out  DATA_W  SRAM write data
mem_dq_oe  out  1  drive enable for the external tristate

Behaviour:
- Reset (Reset=0, async) forces all state and outputs to the following values:
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, hex_data=0.
  - mem_addr=0, all *_n strobes=1, mem_be_n=all 1s, mem_dq_o=0, mem_dq_oe=0.
  - A reset mid-access aborts the access with no response and no hex_data update.
- States:
  - IDLE: req_ready=1. A request is accepted on the rising edge when req_valid=1. At acceptance, addr, we, be and wdata are registered.
    - If addr==IO_ADDR, go to IO.
    - Otherwise go to ACCESS with wait counter = WAIT_CYCLES.
  - ACCESS: mem_ce_n=0. mem_addr holds the registered address.
    - Read: mem_oe_n=0 and mem_be_n=all 0.
    - Write: mem_we_n=0, mem_be_n=~be, mem_dq_oe=1, mem_dq_o=wdata.
    - The counter decrements each cycle. When the counter is 0, a read captures mem_dq_i into resp_rdata, then the state moves to DONE.
    - ACCESS therefore lasts WAIT_CYCLES+1 cycles.
  - IO: one cycle, no SRAM strobes.
    - Read: resp_rdata<=Switches, sampled in this cycle.
    - Write: each byte lane i with be[i]=1 gets hex_data[8i+7:8i] <= wdata lane i; other lanes are held.
    - Next state is DONE.
  - DONE: resp_valid=1 for exactly one cycle. All strobes are deasserted. For a write, mem_dq_oe stays 1 and mem_dq_o is held for one hold cycle. Next state is IDLE.
- Latency from acceptance edge to resp_valid high:
  - SRAM access: WAIT_CYCLES+2 cycles.
  - IO access: 2 cycles.
  - Throughput: one access per latency+1 cycles.
- req_ready=0 in every state except IDLE. req_valid during a busy state is ignored, not queued.
- Write with be=all 0:
  - SRAM: the full ACCESS sequence still runs, but mem_we_n stays 1.
  - IO: hex_data is unchanged.
  - resp_valid still pulses.
- mem_we_n and mem_oe_n are never low in the same cycle. resp_rdata holds its last value between responses. Writes do not modify resp_rdata.
- Addresses differing from IO_ADDR in any bit are SRAM accesses. There is no other aliasing.

Test Plan:
- Reset mid-ACCESS (WAIT_CYCLES=2, read pending) by pulsing Reset=0 -> strobes go to 1 immediately, no resp_valid, req_ready=1 after release, hex_data=0.
- Read from addr 0x00010, mem_dq_i=0xBEEF, WAIT_CYCLES=2 -> mem_ce_n/mem_oe_n low for exactly 3 cycles, resp_valid on the 4th cycle after acceptance, resp_rdata=0xBEEF.
- Write to 0x00020, wdata=0x1234, be=2'b10 -> mem_we_n low for 3 cycles, mem_be_n=2'b01, mem_dq_oe high for 4 cycles, resp_valid on cycle 4.
- Switches=0xA5C3, read at IO_ADDR -> no SRAM strobes, resp_valid 2 cycles after acceptance, resp_rdata=0xA5C3.
- IO write 0xFFFF with be=11, then IO write 0x0012 with be=01 -> hex_data=0xFFFF, then 0xFF12. A following IO write with be=00 leaves hex_data at 0xFF12.
- WAIT_CYCLES=0 build, back-to-back read requests with req_valid held high -> ACCESS lasts 1 cycle, resp_valid every 3 cycles, second request accepted only after the DONE cycle.
